cpu_run_controller: RTL and testbench

- Sequencer upstream of the five-stage CPU core; the core's only inputs are CLOCK, RESET and ENABLE.
- Streams a program into instruction memory, resets the pipeline, then drives the core's ENABLE until the halt word retires from writeback or a timeout expires.
- After the run, it reads out data memory over a ready/valid dump stream and reports the cycle count.

---
 rtl/cpu_run_controller_if.sv | 47 ++++
 rtl/cpu_run_controller.sv | 149 ++++++++++++++
 tb/tb_cpu_run_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_controller_if.sv
// Bundle between the run controller and its surroundings:
// program load stream, memories, core retire port and dump stream.
interface cpu_run_controller_if #(
    parameter int unsigned IMEM_AW = 9,
    parameter int unsigned DMEM_AW = 9
);
    logic               START;
    logic               LOAD_VALID;
    logic               LOAD_READY;
    logic [31:0]        LOAD_DATA;
    logic               LOAD_LAST;
    logic               IM_WE;
    logic [IMEM_AW-1:0] IM_ADDR;
    logic [31:0]        IM_WDATA;
    logic               CPU_RESET;
    logic               CPU_ENABLE;
    logic               RETIRE_VALID;
    logic [31:0]        RETIRE_INSTR;
    logic               DM_RE;
    logic [DMEM_AW-1:0] DM_ADDR;
    logic [31:0]        DM_RDATA;
    logic               DUMP_VALID;
    logic               DUMP_READY;
    logic [31:0]        DUMP_DATA;
    logic               DUMP_LAST;
    logic [31:0]        CYCLE_COUNT;
    logic               TIMEOUT;
    logic               DONE;

    modport slave (
        input  START, LOAD_VALID, LOAD_DATA, LOAD_LAST,
        input  RETIRE_VALID, RETIRE_INSTR, DM_RDATA, DUMP_READY,
        output LOAD_READY, IM_WE, IM_ADDR, IM_WDATA,
        output CPU_RESET, CPU_ENABLE, DM_RE, DM_ADDR,
        output DUMP_VALID, DUMP_DATA, DUMP_LAST,
        output CYCLE_COUNT, TIMEOUT, DONE
    );

    modport master (
        output START, LOAD_VALID, LOAD_DATA, LOAD_LAST,
        output RETIRE_VALID, RETIRE_INSTR, DM_RDATA, DUMP_READY,
        input  LOAD_READY, IM_WE, IM_ADDR, IM_WDATA,
        input  CPU_RESET, CPU_ENABLE, DM_RE, DM_ADDR,
        input  DUMP_VALID, DUMP_DATA, DUMP_LAST,
        input  CYCLE_COUNT, TIMEOUT, DONE
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Run sequencer for the five-stage core: load program, pulse core
// reset, run until halt retires or timeout, then dump data memory.
module cpu_run_controller #(
    parameter int unsigned IMEM_AW    = 9,
    parameter int unsigned DMEM_AW    = 9,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter int unsigned MAX_CYCLES = 1048576
) (
    input logic CLOCK,
    input logic RESET,
    cpu_run_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CPURST, S_RUN,
        S_DUMP_RD, S_DUMP_CAP, S_DUMP_OUT, S_DONE
    } state_t;

    localparam logic [IMEM_AW-1:0] LOAD_MAX = '1;
    localparam logic [DMEM_AW-1:0] DUMP_MAX = '1;
    localparam logic [31:0]        CYC_LAST = 32'(MAX_CYCLES - 1);
    localparam logic [31:0]        CYC_SAT  = '1;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] load_ptr_q, load_ptr_d;
    logic [DMEM_AW-1:0] dump_ptr_q, dump_ptr_d;
    logic [31:0]        cycle_q, cycle_d;
    logic               timeout_q, timeout_d;
    logic               dvalid_q, dvalid_d;
    logic [31:0]        ddata_q, ddata_d;

    logic load_ready;
    logic im_we;
    logic cpu_enable;
    logic dm_re;
    logic halt;

    assign halt = bus.RETIRE_VALID && (bus.RETIRE_INSTR == HALT_WORD);

    // Next-state and per-state strobes
    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        dump_ptr_d = dump_ptr_q;
        cycle_d    = cycle_q;
        timeout_d  = timeout_q;
        dvalid_d   = dvalid_q;
        ddata_d    = ddata_q;
        load_ready = 1'b0;
        im_we      = 1'b0;
        cpu_enable = 1'b0;
        dm_re      = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.START) begin
                    state_d    = S_LOAD;
                    load_ptr_d = '0;
                    dump_ptr_d = '0;
                    cycle_d    = '0;
                    timeout_d  = 1'b0;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (bus.LOAD_VALID) begin
                    im_we = 1'b1;
                    if (bus.LOAD_LAST || load_ptr_q == LOAD_MAX) begin
                        state_d = S_CPURST;
                    end else begin
                        load_ptr_d = load_ptr_q + 1'b1;
                    end
                end
            end
            S_CPURST: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cpu_enable = 1'b1;
                if (cycle_q != CYC_SAT) begin
                    cycle_d = cycle_q + 32'd1;
                end
                if (halt) begin
                    state_d    = S_DUMP_RD;
                    dump_ptr_d = '0;
                end else if (cycle_q == CYC_LAST) begin
                    state_d    = S_DUMP_RD;
                    dump_ptr_d = '0;
                    timeout_d  = 1'b1;
                end
            end
            S_DUMP_RD: begin
                dm_re   = 1'b1;
                state_d = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                ddata_d  = bus.DM_RDATA;
                dvalid_d = 1'b1;
                state_d  = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (bus.DUMP_READY) begin
                    dvalid_d = 1'b0;
                    if (dump_ptr_q == DUMP_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        dump_ptr_d = dump_ptr_q + 1'b1;
                        state_d    = S_DUMP_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            load_ptr_q <= '0;
            dump_ptr_q <= '0;
            cycle_q    <= '0;
            timeout_q  <= 1'b0;
            dvalid_q   <= 1'b0;
            ddata_q    <= '0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            dump_ptr_q <= dump_ptr_d;
            cycle_q    <= cycle_d;
            timeout_q  <= timeout_d;
            dvalid_q   <= dvalid_d;
            ddata_q    <= ddata_d;
        end
    end

    assign bus.LOAD_READY  = load_ready;
    assign bus.IM_WE       = im_we;
    assign bus.IM_ADDR     = load_ptr_q;
    assign bus.IM_WDATA    = bus.LOAD_DATA;
    assign bus.CPU_RESET   = RESET || (state_q == S_CPURST);
    assign bus.CPU_ENABLE  = cpu_enable;
    assign bus.DM_RE       = dm_re;
    assign bus.DM_ADDR     = dump_ptr_q;
    assign bus.DUMP_VALID  = dvalid_q;
    assign bus.DUMP_DATA   = ddata_q;
    assign bus.DUMP_LAST   = dvalid_q && (dump_ptr_q == DUMP_MAX);
    assign bus.CYCLE_COUNT = cycle_q;
    assign bus.TIMEOUT     = timeout_q;
    assign bus.DONE        = (state_q == S_DONE);
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with small memories and
// a 16-cycle run limit.
module tb_cpu_run_controller;
    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   im_wr_cnt = 0;

    logic [31:0] imem [16];
    logic [31:0] dmem [4];

    cpu_run_controller_if #(.IMEM_AW(4), .DMEM_AW(2)) bus ();

    cpu_run_controller #(
        .IMEM_AW(4),
        .DMEM_AW(2),
        .HALT_WORD(32'hFFFF_FFFF),
        .MAX_CYCLES(16)
    ) dut (
        .CLOCK(clock),
        .RESET(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction-memory capture and 1-cycle data-memory read model
    always @(posedge clock) begin
        if (bus.IM_WE) begin
            imem[bus.IM_ADDR] <= bus.IM_WDATA;
            im_wr_cnt <= im_wr_cnt + 1;
        end
        if (bus.DM_RE) begin
            bus.DM_RDATA <= dmem[bus.DM_ADDR];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // START, one LAST word, CPURST; returns in RUN cycle 1
    task automatic load_one(input logic [31:0] w);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("start_count_clr", bus.CYCLE_COUNT, 32'd0);
        check("start_tmo_clr", 32'(bus.TIMEOUT), 32'd0);
        bus.LOAD_VALID = 1'b1;
        bus.LOAD_DATA  = w;
        bus.LOAD_LAST  = 1'b1;
        #1;
        check("load1_addr", 32'(bus.IM_ADDR), 32'd0);
        tick();
        bus.LOAD_VALID = 1'b0;
        bus.LOAD_LAST  = 1'b0;
        tick();
    endtask

    // Dump four words; stall_w holds READY low 5 cycles on that word
    task automatic dump_all(input int stall_w);
        for (int w = 0; w < 4; w++) begin
            check("dm_re", 32'(bus.DM_RE), 32'd1);
            check("dm_addr", 32'(bus.DM_ADDR), 32'(w));
            tick();
            tick();
            check("dump_valid", 32'(bus.DUMP_VALID), 32'd1);
            check("dump_data", bus.DUMP_DATA, dmem[w]);
            check("dump_last", 32'(bus.DUMP_LAST), 32'(w == 3));
            if (w == stall_w) begin
                bus.DUMP_READY = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check("stall_valid", 32'(bus.DUMP_VALID), 32'd1);
                    check("stall_data", bus.DUMP_DATA, dmem[w]);
                end
                bus.DUMP_READY = 1'b1;
            end
            tick();
            check("dump_valid_drop", 32'(bus.DUMP_VALID), 32'd0);
        end
        check("done", 32'(bus.DONE), 32'd1);
    endtask

    initial begin
        reset            = 1'b1;
        bus.START        = 1'b0;
        bus.LOAD_VALID   = 1'b0;
        bus.LOAD_DATA    = '0;
        bus.LOAD_LAST    = 1'b0;
        bus.RETIRE_VALID = 1'b0;
        bus.RETIRE_INSTR = '0;
        bus.DUMP_READY   = 1'b1;
        dmem[0] = 32'hA5A5_0000;
        dmem[1] = 32'h1234_5678;
        dmem[2] = 32'h0BAD_F00D;
        dmem[3] = 32'hCAFE_0003;

        tick();
        tick();
        check("rst_cpu_reset", 32'(bus.CPU_RESET), 32'd1);
        check("rst_enable", 32'(bus.CPU_ENABLE), 32'd0);
        check("rst_count", bus.CYCLE_COUNT, 32'd0);
        check("rst_timeout", 32'(bus.TIMEOUT), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_dvalid", 32'(bus.DUMP_VALID), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_cpu_reset", 32'(bus.CPU_RESET), 32'd0);
        check("idle_ready", 32'(bus.LOAD_READY), 32'd0);

        // Three-word load with VALID toggling
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("load_ready", 32'(bus.LOAD_READY), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.LOAD_VALID = (i % 2 == 0);
            bus.LOAD_DATA  = 32'h1000_0000 + 32'(i);
            bus.LOAD_LAST  = (i == 4);
            #1;
            check("im_we", 32'(bus.IM_WE), 32'(i % 2 == 0));
            if (i % 2 == 0) begin
                check("im_addr", 32'(bus.IM_ADDR), 32'(i / 2));
                check("im_wdata", bus.IM_WDATA, 32'h1000_0000 + 32'(i));
            end
            tick();
        end
        bus.LOAD_VALID = 1'b0;
        bus.LOAD_LAST  = 1'b0;
        check("cpurst_reset", 32'(bus.CPU_RESET), 32'd1);
        check("cpurst_enable", 32'(bus.CPU_ENABLE), 32'd0);
        check("cpurst_ready", 32'(bus.LOAD_READY), 32'd0);
        tick();
        check("run_cpu_reset", 32'(bus.CPU_RESET), 32'd0);
        check("run_enable", 32'(bus.CPU_ENABLE), 32'd1);
        check("im_cnt3", 32'(im_wr_cnt), 32'd3);
        check("imem0", imem[0], 32'h1000_0000);
        check("imem1", imem[1], 32'h1000_0002);
        check("imem2", imem[2], 32'h1000_0004);

        // Halt retires on RUN cycle 10; non-halt retires before it
        for (int i = 1; i <= 9; i++) begin
            bus.RETIRE_VALID = 1'b1;
            bus.RETIRE_INSTR = 32'(i);
            check("run_en_h", 32'(bus.CPU_ENABLE), 32'd1);
            tick();
        end
        bus.RETIRE_INSTR = 32'hFFFF_FFFF;
        check("run_en_10", 32'(bus.CPU_ENABLE), 32'd1);
        tick();
        bus.RETIRE_VALID = 1'b0;
        bus.RETIRE_INSTR = 32'hFFFF_FFFF;
        check("halt_enable", 32'(bus.CPU_ENABLE), 32'd0);
        check("halt_count", bus.CYCLE_COUNT, 32'd10);
        check("halt_timeout", 32'(bus.TIMEOUT), 32'd0);
        dump_all(1);
        tick();
        check("done_hold", 32'(bus.DONE), 32'd1);
        check("done_count", bus.CYCLE_COUNT, 32'd10);
        check("done_no_retire", 32'(bus.CPU_ENABLE), 32'd0);
        bus.RETIRE_VALID = 1'b0;

        // Second program; timeout run with START ignored mid-run
        load_one(32'hB000_0000);
        check("imem0_new", imem[0], 32'hB000_0000);
        check("imem1_kept", imem[1], 32'h1000_0002);
        check("im_cnt4", 32'(im_wr_cnt), 32'd4);
        for (int i = 1; i <= 16; i++) begin
            bus.START = (i == 3);
            check("tmo_enable", 32'(bus.CPU_ENABLE), 32'd1);
            tick();
        end
        bus.START = 1'b0;
        check("tmo_enable_off", 32'(bus.CPU_ENABLE), 32'd0);
        check("tmo_flag", 32'(bus.TIMEOUT), 32'd1);
        check("tmo_count", bus.CYCLE_COUNT, 32'd16);
        dump_all(-1);
        check("tmo_done_flag", 32'(bus.TIMEOUT), 32'd1);

        // Halt on the last allowed cycle wins over timeout
        load_one(32'hC000_0000);
        repeat (15) tick();
        bus.RETIRE_VALID = 1'b1;
        tick();
        bus.RETIRE_VALID = 1'b0;
        check("h16_timeout", 32'(bus.TIMEOUT), 32'd0);
        check("h16_count", bus.CYCLE_COUNT, 32'd16);
        check("h16_enable", 32'(bus.CPU_ENABLE), 32'd0);

        // Reset while holding a dump word
        tick();
        bus.DUMP_READY = 1'b0;
        tick();
        check("mid_dump_valid", 32'(bus.DUMP_VALID), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_comb", 32'(bus.CPU_RESET), 32'd1);
        tick();
        check("rd_dvalid", 32'(bus.DUMP_VALID), 32'd0);
        check("rd_done", 32'(bus.DONE), 32'd0);
        check("rd_count", bus.CYCLE_COUNT, 32'd0);
        check("rd_dm_re", 32'(bus.DM_RE), 32'd0);
        reset = 1'b0;
        bus.DUMP_READY = 1'b1;
        #1;
        check("rd_cpu_reset_off", 32'(bus.CPU_RESET), 32'd0);

        // Reset in the middle of a run
        load_one(32'hD000_0000);
        repeat (5) tick();
        check("mr_count", bus.CYCLE_COUNT, 32'd5);
        check("mr_enable", 32'(bus.CPU_ENABLE), 32'd1);
        reset = 1'b1;
        tick();
        check("mr_enable_off", 32'(bus.CPU_ENABLE), 32'd0);
        check("mr_count_clr", bus.CYCLE_COUNT, 32'd0);
        check("mr_cpu_reset", 32'(bus.CPU_RESET), 32'd1);
        reset = 1'b0;
        tick();
        check("mr_idle_ready", 32'(bus.LOAD_READY), 32'd0);
        check("mr_idle_enable", 32'(bus.CPU_ENABLE), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
